uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// UART receiver; counterpart of uart_tx on the serial line. Oversamples rx at 16x baud using the shared
// baud-rate generator's s_tick. Recovers start/data/optional parity/stop with 3-sample majority vote.
// Presents each frame on a valid/ack holding register with frame, parity and overrun flags.
// PARAMETERS
// DBIT       8   data bits per frame, LSB first (5..8)
// SB_TICK    16  stop-bit length in s_ticks (16 = 1 stop, 24 = 1.5, 32 = 2)
// PARITY_EN  0   1 = parity bit expected after data
// PARITY_ODD 0   1 = odd parity, 0 = even (ignored when PARITY_EN = 0)
// PORTS
// clk          in   1     system clock
// reset_n      in   1     synchronous, active-low reset
// s_tick       in   1     1-clk pulse at 16x baud
// rx           in   1     asynchronous serial input, idles high
// rx_ack       in   1     consumer has taken rx_dout; clears rx_valid
// rx_dout      out  DBIT  last received data word
// rx_valid     out  1     rx_dout holds an unacknowledged word
// rx_done_tick out  1     1-clk pulse per completed frame, good or bad
// frame_err    out  1     stop bit of the rx_dout frame sampled 0
// parity_err   out  1     parity mismatch on the rx_dout frame (always 0 if PARITY_EN = 0)
// overrun_err  out  1     frame completed while rx_valid was set and unacked; sticky until rx_ack
// busy         out  1     state != IDLE
// BEHAVIOUR
// - reset (reset_n = 0 at clk edge): state = IDLE, counters = 0, sync flops = 1, all outputs 0. Aborts any frame.
// - rx passes through a 2-flop synchronizer (rxs). All decisions use rxs.
// - Bit timer s_reg (5 bits) advances only on s_tick. Bit counter n_reg counts data bits.
// - Shift reg b_reg: shift right; new bit enters at MSB [DBIT-1].
// - Majority: samples at s_reg = 7, 8, 9 of each bit. The bit value is the 2-of-3 vote.
// - IDLE: rxs == 0 -> START, s_reg = 0. No s_tick needed.
// - START: vote at tick 9. If vote = 1 (glitch) -> IDLE, no flags, no pulse. Else at s_reg == 15 & s_tick -> DATA, s_reg = 0, n_reg = 0.
// - DATA: vote shifted in at tick 15. If n_reg == DBIT-1 -> PARITY (PARITY_EN) or STOP. Else n_reg++.
// - PARITY: vote at tick 15 -> STOP. Mismatch flag = XOR(data, parity bit) != PARITY_ODD.
// - STOP: vote at ticks SB_TICK-9..SB_TICK-7. Completes on s_tick with s_reg == SB_TICK-7.
//   Stopping mid-stop-bit lets the receiver resync to a back-to-back start edge.
// - Completion: on that same clk edge:
//   - rx_dout <= b_reg; rx_done_tick = 1 for one clk.
//   - frame_err / parity_err <= this frame's results.
//   - rx_valid <= 1.
//   - overrun_err <= 1 if rx_valid = 1 and rx_ack = 0 (old word lost, overwritten).
//   Next state: IDLE if stop vote = 1, else WAIT_IDLE.
// - WAIT_IDLE (break / framing recovery): stay until rxs == 1, then IDLE. A line held low yields exactly one frame_err frame.
// - rx_ack: clears rx_valid and overrun_err on the next edge. Ignored when rx_valid = 0.
// - rx_ack in the same cycle as completion: new word loads, rx_valid stays 1, no overrun.
// - s_tick during reset, or while IDLE: no effect on s_reg.
// - Latency: rx_done_tick rises 1 clk after the stop-bit s_tick (registered). No other pipeline.
// TESTING
// Common setup: s_tick every 10 clk, DBIT = 8, default parameters unless stated.
// 1. Send 0xA5 (8N1), rx_ack held 0.
//    -> rx_done_tick once; rx_dout = 0xA5; rx_valid = 1; all err = 0.
//    -> pulse arrives 9.5 bit-times after the falling edge.
// 2. Two back-to-back frames 0x3C, 0xC3 with no idle gap; rx_ack pulsed after each.
//    -> both received, no errors, 2 pulses.
// 3. rx low for 4 ticks only.
//    -> returns to IDLE; no pulse; busy drops; rx_valid unchanged.
// 4. Frame 0x00 with stop = 0, line held low for 3 frame times.
//    -> one pulse, frame_err = 1; no further frames until rx returns high; next 0x55 frame clean.
// 5. PARITY_EN = 1, PARITY_ODD = 0: send 0x07 with parity bit 0.
//    -> parity_err = 1. Send 0x07 with parity bit 1 -> parity_err = 0.
// 6. Receive 0x11, no ack, then 0x22.
//    -> rx_dout = 0x22, overrun_err = 1. rx_ack -> rx_valid = 0, overrun_err = 0.
//    Also: reset_n = 0 mid-data -> all outputs 0, next frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-of-3 majority vote per bit,
// optional parity, valid/ack holding register with error flags.
// Ports:
//   clk, reset_n (sync, active-low), s_tick (16x baud pulse)
//   rx (async serial in), rx_ack (consumer took rx_dout)
//   rx_dout, rx_valid, rx_done_tick, frame_err, parity_err,
//   overrun_err, busy
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_ack,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_valid,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun_err,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  localparam logic [4:0] STOP_LO  = 5'(SB_TICK - 9);
  localparam logic [4:0] STOP_END = 5'(SB_TICK - 7);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
  localparam bit         PEN      = (PARITY_EN != 0);
  localparam logic       ODD      = (PARITY_ODD != 0);

  function automatic logic maj(input logic a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t          state_q, state_d;
  logic            rx_s1_q, rxs_q;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [2:0]      smp_q, smp_d;
  logic            par_q, par_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            ovr_q, ovr_d;

  logic [4:0] lo;
  logic       vote3, vote_now;
  logic       bit_end, start_glitch, stop_done;

  // Sample window sits mid-bit; the stop bit window is shifted so
  // the frame can finish early and catch a back-to-back start edge.
  assign lo       = (state_q == STOP) ? STOP_LO : 5'd7;
  assign vote3    = maj(smp_q[0], smp_q[1], smp_q[2]);
  // Vote taken on the tick of the third sample itself.
  assign vote_now = maj(smp_q[0], smp_q[1], rxs_q);

  assign bit_end      = s_tick && (s_q == 5'd15);
  assign start_glitch = (state_q == START) && s_tick &&
                        (s_q == 5'd9) && vote_now;
  assign stop_done    = (state_q == STOP) && s_tick &&
                        (s_q == STOP_END);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      smp_q   <= '0;
      par_q   <= 1'b0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_s1_q <= rx;
      rxs_q   <= rx_s1_q;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      smp_q   <= smp_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (!rxs_q) state_d = START;
      START:
        if (start_glitch) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      DATA:
        if (bit_end && n_q == LAST_BIT)
          state_d = PEN ? PARITY : STOP;
      PARITY:
        if (bit_end) state_d = STOP;
      STOP:
        if (stop_done)
          state_d = vote_now ? IDLE : WAIT_IDLE;
      WAIT_IDLE:
        if (rxs_q) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    s_d   = s_q;
    n_d   = n_q;
    b_d   = b_q;
    smp_d = smp_q;
    par_d = par_q;
    if (state_q != IDLE && s_tick) begin
      s_d = s_q + 5'd1;
      if (s_q == lo)         smp_d[0] = rxs_q;
      if (s_q == lo + 5'd1)  smp_d[1] = rxs_q;
      if (s_q == lo + 5'd2)  smp_d[2] = rxs_q;
    end
    unique case (state_q)
      IDLE:
        if (!rxs_q) begin
          s_d   = '0;
          par_d = 1'b0;
        end
      START:
        if (bit_end) begin
          s_d = '0;
          n_d = '0;
        end
      DATA:
        if (bit_end) begin
          s_d = '0;
          b_d = {vote3, b_q[DBIT-1:1]};
          if (n_q != LAST_BIT) n_d = n_q + 3'd1;
        end
      PARITY:
        if (bit_end) begin
          s_d   = '0;
          par_d = ((^b_q) ^ vote3) != ODD;
        end
      default: ;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    ovr_d   = ovr_q;
    done_d  = stop_done;
    if (stop_done) begin
      dout_d  = b_q;
      ferr_d  = ~vote_now;
      perr_d  = par_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ack;
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign rx_dout      = dout_q;
  assign rx_valid     = valid_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;
  assign overrun_err  = ovr_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one 8N1 instance and one 8E1
// instance, random and directed frames against a frame-level model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n, s_tick;
  logic       rx_a, rx_b, ack_a, ack_b;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, done_a, fe_a, pe_a, ov_a, busy_a;
  logic       valid_b, done_b, fe_b, pe_b, ov_b, busy_b;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_done_a = 0;
  bit   pend_a = 0;
  bit   pend_b = 0;

  localparam int BIT_CLK = 160;

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_a),
    .rx_ack(ack_a), .rx_dout(dout_a), .rx_valid(valid_a),
    .rx_done_tick(done_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun_err(ov_a), .busy(busy_a)
  );

  uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx_b),
    .rx_ack(ack_b), .rx_dout(dout_b), .rx_valid(valid_b),
    .rx_done_tick(done_b), .frame_err(fe_b), .parity_err(pe_b),
    .overrun_err(ov_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (reset_n && done_a) begin
      exp_t e;
      t_done_a = cyc;
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_frame dout=%h", dout_a);
      end else begin
        e = qa.pop_front();
        if (dout_a !== e.d || fe_a !== e.fe || pe_a !== e.pe ||
            ov_a !== e.ov || valid_a !== 1'b1) begin
          errors++;
          $display("FAIL a_frame got d=%h fe=%b pe=%b ov=%b v=%b want d=%h fe=%b pe=%b ov=%b v=1",
                   dout_a, fe_a, pe_a, ov_a, valid_a, e.d, e.fe, e.pe, e.ov);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && done_b) begin
      exp_t e;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_frame dout=%h", dout_b);
      end else begin
        e = qb.pop_front();
        if (dout_b !== e.d || fe_b !== e.fe || pe_b !== e.pe ||
            ov_b !== e.ov || valid_b !== 1'b1) begin
          errors++;
          $display("FAIL b_frame got d=%h fe=%b pe=%b ov=%b v=%b want d=%h fe=%b pe=%b ov=%b v=1",
                   dout_b, fe_b, pe_b, ov_b, valid_b, e.d, e.fe, e.pe, e.ov);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic setrx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic bitw();
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic do_ack(input bit sel);
    if (sel) ack_b = 1'b1;
    else     ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
    if (sel) pend_b = 0;
    else     pend_a = 0;
  endtask

  // Frame-level model: data as sent, frame error when stop is low,
  // even-parity error on instance b when the count of ones is odd,
  // overrun when the previous word was never acknowledged.
  task automatic send(input bit sel, input logic [7:0] d,
                      input logic pb, input logic stop,
                      input bit ack_after);
    exp_t e;
    e.d  = d;
    e.fe = ~stop;
    e.pe = sel ? ((($countones(d) + int'(pb)) % 2) == 1) : 1'b0;
    if (sel) begin
      e.ov = pend_b;
      pend_b = 1;
      qb.push_back(e);
    end else begin
      e.ov = pend_a;
      pend_a = 1;
      qa.push_back(e);
    end
    setrx(sel, 1'b0);
    bitw();
    for (int i = 0; i < 8; i++) begin
      setrx(sel, d[i]);
      bitw();
    end
    if (sel) begin
      setrx(sel, pb);
      bitw();
    end
    setrx(sel, stop);
    bitw();
    if (ack_after) do_ack(sel);
  endtask

  initial begin
    int t0;
    reset_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    ack_a = 1'b0;
    ack_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_outputs_a", {dout_a, valid_a, done_a, fe_a, pe_a, ov_a, busy_a}, 0);
    chk("reset_outputs_b", {dout_b, valid_b, done_b, fe_b, pe_b, ov_b, busy_b}, 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    // 0xA5 8N1, no ack; pulse about 9.5 bit times after the edge
    t0 = cyc;
    send(0, 8'hA5, 1'b0, 1'b1, 0);
    chk("a5_valid_held", valid_a, 1);
    checks++;
    if (t_done_a - t0 < 1500 || t_done_a - t0 > 1570) begin
      errors++;
      $display("FAIL a5_latency got %0d clk want 1500..1570", t_done_a - t0);
    end
    do_ack(0);
    chk("a5_ack_clears", valid_a, 0);

    // back-to-back frames
    send(0, 8'h3C, 1'b0, 1'b1, 1);
    send(0, 8'hC3, 1'b0, 1'b1, 1);
    repeat (20) @(negedge clk);

    // short start glitch
    send(0, 8'h6E, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy", busy_a, 1);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_idle", busy_a, 0);
    chk("glitch_valid", valid_a, 32'(pend_a));
    do_ack(0);

    // break: stop low then line low for three frames
    send(0, 8'h00, 1'b0, 1'b0, 1);
    repeat (30) bitw();
    chk("break_waits", busy_a, 1);
    rx_a = 1'b1;
    bitw();
    chk("break_recovered", busy_a, 0);
    send(0, 8'h55, 1'b0, 1'b1, 1);

    // parity (even) on instance b
    send(1, 8'h07, 1'b0, 1'b1, 1);
    send(1, 8'h07, 1'b1, 1'b1, 1);
    repeat (20) @(negedge clk);

    // overrun
    send(0, 8'h11, 1'b0, 1'b1, 0);
    send(0, 8'h22, 1'b0, 1'b1, 0);
    chk("ovr_set", {valid_a, ov_a}, 2'b11);
    do_ack(0);
    chk("ovr_cleared", {valid_a, ov_a}, 2'b00);

    // randomized frames
    for (int k = 0; k < 14; k++) begin
      bit         sel, ak;
      logic [7:0] d;
      logic       pb, stop;
      sel  = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      pb   = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      ak   = 1'($urandom_range(0, 1));
      send(sel, d, pb, stop, ak);
      if (!stop) begin
        setrx(sel, 1'b1);
        repeat (30) @(negedge clk);
      end else begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
    end
    repeat (40) @(negedge clk);
    do_ack(0);
    do_ack(1);

    // reset in the middle of a data bit
    rx_a = 1'b0;
    bitw();
    rx_a = 1'b1;
    bitw();
    rx_a = 1'b0;
    repeat (80) @(negedge clk);
    chk("pre_reset_busy", busy_a, 1);
    reset_n = 1'b0;
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset_a", {dout_a, valid_a, done_a, fe_a, pe_a, ov_a, busy_a}, 0);
    chk("midreset_b", {dout_b, valid_b, done_b, fe_b, pe_b, ov_b, busy_b}, 0);
    reset_n = 1'b1;
    pend_a = 0;
    pend_b = 0;
    repeat (200) @(negedge clk);
    send(0, 8'h9C, 1'b0, 1'b1, 0);
    chk("post_reset_dout", dout_a, 8'h9C);
    do_ack(0);

    for (int i = 0; i < 5000 && (qa.size() != 0 || qb.size() != 0); i++)
      @(negedge clk);
    chk("queues_drained", 32'(qa.size() + qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
